// File: rtl/xram_resp.sv
// rtl/xram_resp.sv - byte-wide XRAM responder with programmable wait states
// Optional feature macro: XRAM_RESP_RANGE_CHK_EN (out-of-range detection and sticky error flag).
module xram_resp #(
    parameter int WAIT_STATES = 1,
    parameter int MEM_DEPTH   = 8192,
    parameter int ADDR_W      = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] xram_addr,
    input  logic [7:0]  xram_data_in,
    output logic [7:0]  xram_data_out,
    input  logic        xram_stb,
    input  logic        xram_wr,
    output logic        xram_ack,
    output logic [1:0]  resp_state,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10,
        ST_BAD  = 2'b11
    } state_t;

    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  dout_q, dout_d;
    logic        enter_ack;
    logic        in_range;
    logic        commit;
    logic [ADDR_W-1:0] idx;

    logic [7:0] mem [MEM_DEPTH];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (xram_stb) begin
                    addr_d  = xram_addr;
                    wr_d    = xram_wr;
                    wdata_d = xram_data_in;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_LOAD;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The *_d request view already holds the just-captured request when
    // IDLE jumps straight to ACK, so one path serves every wait setting.
    assign idx       = addr_d[ADDR_W-1:0];
    assign enter_ack = (state_d == ST_ACK);

`ifdef XRAM_RESP_RANGE_CHK_EN
    logic err_q, err_d;
    assign in_range = ({16'h0000, addr_d} < 32'(MEM_DEPTH));
    assign err_d    = err_q | (enter_ack & ~in_range);
    assign resp_err = err_q;
`else
    logic unused_addr_hi;
    assign in_range       = 1'b1;
    assign unused_addr_hi = ^addr_d[15:ADDR_W];
    assign resp_err       = 1'b0;
`endif

    assign commit = enter_ack & wr_d & in_range;

    always_comb begin
        dout_d = dout_q;
        if (enter_ack && !wr_d) begin
            dout_d = in_range ? mem[idx] : 8'hFF;
        end
    end

    // Gated by rst so an in-flight write is never committed during reset.
    always_ff @(posedge clk) begin
        if (rst && commit) begin
            mem[idx] <= wdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            wr_q    <= 1'b0;
            wdata_q <= 8'h00;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
        end
    end

`ifdef XRAM_RESP_RANGE_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

    assign xram_ack      = (state_q == ST_ACK);
    assign xram_data_out = dout_q;
    assign resp_state    = state_q;

endmodule

// File: tb/tb_xram_resp.sv
// tb/tb_xram_resp.sv - scoreboard bench for xram_resp at WAIT_STATES 0, 1 and 3
module tb_xram_resp;

    logic        clk;
    logic        rst;
    logic [15:0] addr  [3];
    logic [7:0]  din   [3];
    logic [7:0]  dout  [3];
    logic        stb   [3];
    logic        wr    [3];
    logic        ack   [3];
    logic [1:0]  state [3];
    logic        err   [3];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         inst;
        int         ack_cyc;
        logic [7:0] data;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] model     [3][8192];
    logic [7:0] last_dout [3];
    logic       prev_ack  [3];

    function automatic int ws_of(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        xram_resp #(
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3)),
            .MEM_DEPTH  (8192),
            .ADDR_W     (13)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .xram_addr    (addr[g]),
            .xram_data_in (din[g]),
            .xram_data_out(dout[g]),
            .xram_stb     (stb[g]),
            .xram_wr      (wr[g]),
            .xram_ack     (ack[g]),
            .resp_state   (state[g]),
            .resp_err     (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model of the backing array and read register; pushes the expected ack.
    task automatic push_exp(input int g, input logic w, input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        logic oob;
        oob = 1'b0;
`ifdef XRAM_RESP_RANGE_CHK_EN
        oob = (a >= 16'h2000);
`endif
        e.inst    = g;
        e.ack_cyc = cyc + 1 + ws_of(g);
        if (w) begin
            if (!oob) model[g][a[12:0]] = d;
            e.data = last_dout[g];
        end else begin
            e.data = oob ? 8'hFF : model[g][a[12:0]];
            last_dout[g] = e.data;
        end
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic xfer(input int g, input logic w, input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        stb[g] = 1'b1; wr[g] = w; addr[g] = a; din[g] = d;
        push_exp(g, w, a, d);
        @(posedge clk); #1;
        stb[g] = 1'b0;
        wait_drain();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int g = 0; g < 3; g++) begin
                if (ack[g]) begin
                    if (prev_ack[g]) chk("ack_back_to_back", 1, 0);
                    if (sb.size() == 0) begin
                        chk("unexpected_ack", g, 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("ack_inst", g, e.inst);
                        chk("ack_cycle", cyc, e.ack_cyc);
                        chk("data_out", dout[g], e.data);
                    end
                end
                prev_ack[g] = ack[g];
            end
        end
    end

    initial begin
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            stb[g] = 1'b0; wr[g] = 1'b0; addr[g] = 16'h0; din[g] = 8'h0;
            last_dout[g] = 8'h00; prev_ack[g] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("rst_state", state[g], 2'b00);
            chk("rst_ack", ack[g], 1'b0);
            chk("rst_dout", dout[g], 8'h00);
            chk("rst_err", err[g], 1'b0);
        end
        rst = 1'b1;

        // WAIT_STATES=1: write then read back
        xfer(1, 1'b1, 16'h0010, 8'hA5);
        xfer(1, 1'b0, 16'h0010, 8'h00);

        // WAIT_STATES=0: stb held across a read stream
        for (int i = 0; i < 4; i++) xfer(0, 1'b1, 16'(i), 8'(8'h11 * (i + 1)));
        @(posedge clk); #1;
        stb[0] = 1'b1; wr[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            addr[0] = 16'(i);
            push_exp(0, 1'b0, 16'(i), 8'h00);
            @(posedge clk); #1;
            if (i == 3) stb[0] = 1'b0;
            else begin
                @(posedge clk); #1;
            end
        end
        wait_drain();

        // WAIT_STATES=3: request changes during WAIT are ignored
        xfer(2, 1'b1, 16'h0100, 8'h99);
        @(posedge clk); #1;
        stb[2] = 1'b1; wr[2] = 1'b1; addr[2] = 16'h0200; din[2] = 8'hC3;
        push_exp(2, 1'b1, 16'h0200, 8'hC3);
        @(posedge clk); #1;
        stb[2] = 1'b0; addr[2] = 16'h0100; din[2] = 8'hEE; wr[2] = 1'b0;
        chk("ws3_in_wait", state[2], 2'b01);
        wait_drain();
        xfer(2, 1'b0, 16'h0200, 8'h00);
        xfer(2, 1'b0, 16'h0100, 8'h00);

        // Reset during WAIT aborts an uncommitted write
        xfer(1, 1'b1, 16'h0020, 8'h00);
        xfer(1, 1'b0, 16'h0010, 8'h00);
        @(posedge clk); #1;
        stb[1] = 1'b1; wr[1] = 1'b1; addr[1] = 16'h0020; din[1] = 8'h5A;
        @(posedge clk); #1;
        stb[1] = 1'b0;
        chk("abort_in_wait", state[1], 2'b01);
        rst = 1'b0;
        #1;
        chk("abort_state", state[1], 2'b00);
        chk("abort_ack", ack[1], 1'b0);
        chk("abort_dout", dout[1], 8'h00);
        for (int g = 0; g < 3; g++) last_dout[g] = 8'h00;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        xfer(1, 1'b0, 16'h0020, 8'h00);
        chk("abort_readback", dout[1], 8'h00);

`ifdef XRAM_RESP_RANGE_CHK_EN
        xfer(1, 1'b1, 16'h2000, 8'h77);
        chk("oob_err_set", err[1], 1'b1);
        xfer(1, 1'b0, 16'h2000, 8'h00);
        chk("oob_read_ff", dout[1], 8'hFF);
        chk("oob_err_sticky", err[1], 1'b1);
`else
        xfer(1, 1'b1, 16'h2005, 8'h77);
        xfer(1, 1'b0, 16'h0005, 8'h00);
        chk("alias_read", dout[1], 8'h77);
        chk("alias_err", err[1], 1'b0);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xram_resp.md
XRAM_RESP -- requirements
Module: xram_resp

Interface
REQ-001 SHALL provide parameter WAIT_STATES, default 1, meaning idle cycles inserted between request capture and ack (legal range 0..15).
REQ-002 SHALL provide parameter MEM_DEPTH, default 8192, meaning number of byte locations in the backing array.
REQ-003 SHALL provide parameter ADDR_W, default 13, meaning index width into the array (log2 of MEM_DEPTH).
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port xram_addr, input, 16 bits: byte address from the initiator.
REQ-007 SHALL have port xram_data_in, input, 8 bits: write data from the initiator.
REQ-008 SHALL have port xram_data_out, output, 8 bits: read data to the initiator.
REQ-009 SHALL have port xram_stb, input, 1 bit: request valid.
REQ-010 SHALL have port xram_wr, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port xram_ack, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port resp_state, output, 2 bits: current FSM state, for verification.
REQ-013 SHALL have port resp_err, output, 1 bit: sticky out-of-range flag.

Function
REQ-014 SHALL implement FSM states IDLE=2'b00, WAIT=2'b01, ACK=2'b10; 2'b11 is unreachable and SHALL return to IDLE.
REQ-015 In IDLE with xram_stb=1, SHALL capture xram_addr, xram_wr and xram_data_in into request registers, then go to WAIT if WAIT_STATES>0, else ACK.
REQ-016 On leaving IDLE to WAIT, SHALL load a 4-bit counter with WAIT_STATES-1; in WAIT it SHALL decrement, going to ACK when the counter is 0.
REQ-017 On the edge entering ACK, a write SHALL commit the captured data to mem[captured index], and a read SHALL load xram_data_out from mem[captured index].
REQ-018 xram_ack SHALL be 1 only in ACK, which always lasts exactly one cycle and is always followed by IDLE.
REQ-019 Latency SHALL be: stb sampled in IDLE at cycle 0, xram_ack high in cycle 1+WAIT_STATES, read data valid in that same cycle.
REQ-020 xram_data_out SHALL hold its last value outside ACK cycles; writes SHALL NOT change it.
REQ-021 xram_stb and xram_wr SHALL be ignored in WAIT and ACK; an initiator holding stb across ACK gets its next request captured in the following IDLE cycle (minimum 2 cycles per transfer).
REQ-022 If stb deasserts after capture, the transaction SHALL still complete, including the write commit and the ack pulse.
REQ-023 Back-to-back transfers SHALL be read-after-write coherent: a read to an address written by the previous transfer SHALL return the new data.
REQ-024 The backing array SHALL NOT be reset or initialised by the block.

Reset
REQ-025 Asserting rst (low) SHALL immediately force state IDLE, xram_ack=0, xram_data_out=8'h00, wait counter 0, resp_err=0, and clear the request registers.
REQ-026 Reset mid-transaction SHALL abort it; a write not yet committed SHALL NOT modify the array.
REQ-027 After rst deasserts, the first rising edge with xram_stb=1 SHALL capture a request.

Configuration
REQ-028 With macro XRAM_RESP_RANGE_CHK_EN defined, a captured address >= MEM_DEPTH SHALL drop the write, return 8'hFF on a read, still pulse xram_ack, and set resp_err until reset.
REQ-029 Without XRAM_RESP_RANGE_CHK_EN, the address SHALL be truncated to xram_addr[ADDR_W-1:0] (wrap-around aliasing), and resp_err SHALL be tied to 0.

Verification
REQ-030 WAIT_STATES=1: write 8'hA5 to 16'h0010, stb held 1 cycle -> xram_ack high exactly in cycle 2 for one cycle; a following read of 16'h0010 returns 8'hA5 with ack.
REQ-031 WAIT_STATES=0: hold stb=1 and stream reads of addresses 0..3 (pre-written 8'h11..8'h44) -> acks every 2nd cycle, data 11,22,33,44, never two consecutive ack cycles.
REQ-032 WAIT_STATES=3: issue a write, drop stb after 1 cycle, change addr/data during WAIT -> ack in cycle 4, the original addr/data are committed, and the changed values are ignored.
REQ-033 Assert rst low in WAIT of a write of 8'h5A to 16'h0020 that previously held 8'h00 -> ack never pulses, state=00, data_out=00, a readback returns 8'h00.
REQ-034 With XRAM_RESP_RANGE_CHK_EN defined: write 8'h77 to 16'h2000 then read it -> both acked, read returns 8'hFF, resp_err=1 from the first access until reset.
REQ-035 Without the macro: write 8'h77 to 16'h2005 -> read of 16'h0005 returns 8'h77, and resp_err stays 0.
